bitbakery_serial_rx: RTL and testbench

Serial receiver for the BitBakery debug/telemetry link. It samples the line driven by the game-side serial transmitter and decodes each character into a byte. It reassembles the four tagged bytes (tags 00, 01, 10, 11 in bits [7:6]) into one frame, then presents the decoded game status (minigame, state, jogada, dificuldade) with a one-cycle `pronto` pulse. It sits on the monitoring board or in the loopback bench, opposite the transmitter.

---
 rtl/bitbakery_serial_pkg.sv | 24 ++
 rtl/bitbakery_serial_rx_byte.sv | 150 +++++++++++++++
 rtl/bitbakery_serial_rx.sv | 133 +++++++++++++
 tb/tb_bitbakery_serial_rx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bitbakery_serial_pkg.sv
// Shared constants for the BitBakery serial receiver: frame tags, bit-level
// FSM state encodings and the default baud divisor.
// Optional feature macro used by this codebase slice: BITBAKERY_RX_PARITY_EN.
package bitbakery_serial_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 16;

  // Tags carried in bits [7:6] of each byte of a frame
  localparam logic [1:0] TAG_D0 = 2'b00;
  localparam logic [1:0] TAG_D1 = 2'b01;
  localparam logic [1:0] TAG_D2 = 2'b10;
  localparam logic [1:0] TAG_D3 = 2'b11;

  // Bit-level receive FSM states (also exported on db_estado_rx)
  typedef enum logic [2:0] {
    ST_OCIOSO        = 3'd0,
    ST_INICIO        = 3'd1,
    ST_DADOS         = 3'd2,
    ST_PARIDADE      = 3'd3,
    ST_PARADA        = 3'd4,
    ST_ESPERA_OCIOSO = 3'd5
  } rx_state_e;

endpackage

// File: rtl/bitbakery_serial_rx_byte.sv
// Character-level receiver: 2-FF input synchronizer, bit FSM, baud counter
// and shift register. Emits one byte_ok pulse per accepted character.
// With BITBAKERY_RX_PARITY_EN defined an even parity bit follows the data.
module bitbakery_serial_rx_byte
  import bitbakery_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic       byte_ok,
  output logic [7:0] dado,
  output logic       erro_quadro,
  output logic       erro_paridade,
  output logic [2:0] estado_rx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  // Start bit is sampled at its midpoint, every later bit one full period on
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       sync_q, sync_d;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_ok_q, byte_ok_d;
  logic             erro_quadro_q, erro_quadro_d;
  logic             line_s;
  logic             sample_tick;

  assign line_s = sync_q[1];

  // Two-stage synchronizer input shift
  always_comb begin
    sync_d = {sync_q[0], entrada_serial};
  end

  // Sample point: half period in the start bit, full period afterwards
  always_comb begin
    sample_tick = 1'b0;
    case (state_q)
      ST_INICIO:   sample_tick = (cnt_q == CNT_HALF);
      ST_DADOS:    sample_tick = (cnt_q == CNT_FULL);
`ifdef BITBAKERY_RX_PARITY_EN
      ST_PARIDADE: sample_tick = (cnt_q == CNT_FULL);
`endif
      ST_PARADA:   sample_tick = (cnt_q == CNT_FULL);
      default:     sample_tick = 1'b0;
    endcase
  end

  // Next-state logic of the bit FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OCIOSO: if (!line_s) state_d = ST_INICIO;
      ST_INICIO: if (sample_tick) state_d = line_s ? ST_OCIOSO : ST_DADOS;
      ST_DADOS: begin
        if (sample_tick && bit_cnt_q == 3'd7) begin
`ifdef BITBAKERY_RX_PARITY_EN
          state_d = ST_PARIDADE;
`else
          state_d = ST_PARADA;
`endif
        end
      end
`ifdef BITBAKERY_RX_PARITY_EN
      // A bad parity bit aborts the character; the stop bit is not checked
      ST_PARIDADE: if (sample_tick) state_d = (^{shift_q, line_s}) ? ST_ESPERA_OCIOSO : ST_PARADA;
`endif
      ST_PARADA: if (sample_tick) state_d = line_s ? ST_OCIOSO : ST_ESPERA_OCIOSO;
      ST_ESPERA_OCIOSO: if (line_s) state_d = ST_OCIOSO;
      default: state_d = ST_OCIOSO;
    endcase
  end

  // Datapath and pulse outputs: baud counter, bit counter, shift register
  always_comb begin
    cnt_d         = cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    byte_ok_d     = 1'b0;
    erro_quadro_d = 1'b0;
    case (state_q)
      ST_OCIOSO: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
      end
      ST_ESPERA_OCIOSO: cnt_d = '0;
      default: cnt_d = sample_tick ? '0 : cnt_q + 1'b1;
    endcase
    if (state_q == ST_DADOS && sample_tick) begin
      shift_d   = {line_s, shift_q[7:1]};
      bit_cnt_d = bit_cnt_q + 1'b1;
    end
    if (state_q == ST_PARADA && sample_tick) begin
      byte_ok_d     = line_s;
      erro_quadro_d = ~line_s;
    end
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q        <= 2'b11;
      state_q       <= ST_OCIOSO;
      cnt_q         <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      byte_ok_q     <= 1'b0;
      erro_quadro_q <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      byte_ok_q     <= byte_ok_d;
      erro_quadro_q <= erro_quadro_d;
    end
  end

`ifdef BITBAKERY_RX_PARITY_EN
  logic erro_paridade_q, erro_paridade_d;

  // Parity error pulse: data XOR parity must be even
  always_comb begin
    erro_paridade_d = (state_q == ST_PARIDADE) && sample_tick && (^{shift_q, line_s});
  end

  // Parity error pulse register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) erro_paridade_q <= 1'b0;
    else        erro_paridade_q <= erro_paridade_d;
  end

  assign erro_paridade = erro_paridade_q;
`else
  assign erro_paridade = 1'b0;
`endif

  assign byte_ok     = byte_ok_q;
  assign dado        = shift_q;
  assign erro_quadro = erro_quadro_q;
  assign estado_rx   = state_q;

endmodule

// File: rtl/bitbakery_serial_rx.sv
// BitBakery serial receiver top: reassembles four tagged bytes into a frame,
// publishes D0..D3 atomically and decodes the game status fields.
// Parity support follows the BITBAKERY_RX_PARITY_EN macro (see byte receiver).
module bitbakery_serial_rx
  import bitbakery_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [7:0] D0,
  output logic [7:0] D1,
  output logic [7:0] D2,
  output logic [7:0] D3,
  output logic [1:0] minigame,
  output logic [3:0] estado,
  output logic [6:0] jogada,
  output logic       dificuldade,
  output logic       pronto,
  output logic       erro_quadro,
  output logic       erro_paridade,
  output logic       erro_sequencia,
  output logic [2:0] db_estado_rx
);

  logic       byte_ok;
  logic [7:0] dado;
  logic [1:0] tag;

  bitbakery_serial_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte (
    .clock          (clock),
    .reset          (reset),
    .entrada_serial (entrada_serial),
    .byte_ok        (byte_ok),
    .dado           (dado),
    .erro_quadro    (erro_quadro),
    .erro_paridade  (erro_paridade),
    .estado_rx      (db_estado_rx)
  );

  assign tag = dado[7:6];

  logic [1:0] expected_q, expected_d;
  logic       take_d0, take_next, slot_wr, publish_d;
  logic       pub_q, pub_d;
  logic       pronto_q, pronto_d;
  logic       erro_seq_q, erro_seq_d;
  logic [7:0] shadow_q [3];
  logic [7:0] shadow_d [3];
  logic [7:0] dout_q [4];
  logic [7:0] dout_d [4];

  // Tag sequencing: tag 00 always (re)starts a frame, others must be in order
  always_comb begin
    take_d0    = byte_ok && (tag == TAG_D0);
    take_next  = byte_ok && (tag != TAG_D0) && (tag == expected_q);
    slot_wr    = take_d0 || take_next;
    publish_d  = take_next && (tag == TAG_D3);
    erro_seq_d = byte_ok && (tag != TAG_D0) && (tag != expected_q);
    pub_d      = publish_d;
    pronto_d   = pub_q;
    expected_d = expected_q;
    if (take_d0)         expected_d = TAG_D1;
    else if (publish_d)  expected_d = TAG_D0;
    else if (take_next)  expected_d = expected_q + 2'b01;
    else if (erro_seq_d) expected_d = TAG_D0;
  end

  // Sequencer and pulse registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      expected_q <= TAG_D0;
      pub_q      <= 1'b0;
      pronto_q   <= 1'b0;
      erro_seq_q <= 1'b0;
    end else begin
      expected_q <= expected_d;
      pub_q      <= pub_d;
      pronto_q   <= pronto_d;
      erro_seq_q <= erro_seq_d;
    end
  end

  // Shadow slots 0..2; tag 11 goes straight to the output register
  for (genvar gi = 0; gi < 3; gi++) begin : g_shadow
    // Capture an accepted byte into its tag's slot
    always_comb begin
      shadow_d[gi] = (slot_wr && tag == 2'(gi)) ? dado : shadow_q[gi];
    end

    // Shadow slot register
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) shadow_q[gi] <= '0;
      else        shadow_q[gi] <= shadow_d[gi];
    end
  end

  // Output bytes change only when a complete frame is published
  for (genvar gi = 0; gi < 4; gi++) begin : g_dout
    if (gi == 3) begin : g_last
      // Last byte comes directly from the receiver on publication
      always_comb begin
        dout_d[gi] = publish_d ? dado : dout_q[gi];
      end
    end else begin : g_slot
      // Earlier bytes come from their shadow slots on publication
      always_comb begin
        dout_d[gi] = publish_d ? shadow_q[gi] : dout_q[gi];
      end
    end

    // Published output register
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) dout_q[gi] <= '0;
      else        dout_q[gi] <= dout_d[gi];
    end
  end

  assign D0             = dout_q[0];
  assign D1             = dout_q[1];
  assign D2             = dout_q[2];
  assign D3             = dout_q[3];
  assign minigame       = dout_q[0][5:4];
  assign estado         = dout_q[0][3:0];
  assign jogada         = {dout_q[2][5], dout_q[1][5:0]};
  assign dificuldade    = dout_q[2][4];
  assign pronto         = pronto_q;
  assign erro_sequencia = erro_seq_q;

endmodule

// File: tb/tb_bitbakery_serial_rx.sv
// Self-checking bench for bitbakery_serial_rx: directed frames from the test
// plan followed by randomized tagged bytes, checked against a queue-based
// frame model. Honours BITBAKERY_RX_PARITY_EN to match the DUT build.
module tb_bitbakery_serial_rx;
  import bitbakery_serial_pkg::*;

  localparam int CPB = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       entrada_serial = 1'b1;
  logic [7:0] D0, D1, D2, D3;
  logic [1:0] minigame;
  logic [3:0] estado;
  logic [6:0] jogada;
  logic       dificuldade, pronto, erro_quadro, erro_paridade, erro_sequencia;
  logic [2:0] db_estado_rx;

  bitbakery_serial_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock          (clock),
    .reset          (reset),
    .entrada_serial (entrada_serial),
    .D0             (D0),
    .D1             (D1),
    .D2             (D2),
    .D3             (D3),
    .minigame       (minigame),
    .estado         (estado),
    .jogada         (jogada),
    .dificuldade    (dificuldade),
    .pronto         (pronto),
    .erro_quadro    (erro_quadro),
    .erro_paridade  (erro_paridade),
    .erro_sequencia (erro_sequencia),
    .db_estado_rx   (db_estado_rx)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Observed pulse counts (cycles high) and the frame seen while pronto is high
  int          n_pronto = 0, n_seq = 0, n_quadro = 0, n_par = 0;
  logic [31:0] snap = 32'h0;

  // Reference model: partial frame as a queue, published frame, expected counts
  logic [7:0]  part_q[$];
  logic [7:0]  m_out [4];
  logic [31:0] m_snap = 32'h0;
  int          m_pronto = 0, m_seq = 0, m_quadro = 0, m_par = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulse monitor, sampled on the falling edge
  always @(negedge clock) begin
    if (reset) begin
      if (pronto) begin
        n_pronto <= n_pronto + 1;
        snap     <= {D0, D1, D2, D3};
      end
      if (erro_sequencia) n_seq    <= n_seq + 1;
      if (erro_quadro)    n_quadro <= n_quadro + 1;
      if (erro_paridade)  n_par    <= n_par + 1;
    end
  end

  // Model of frame assembly: queue position must equal the byte's tag
  task automatic model_byte(input logic [7:0] b, input bit bad_stop, input bit bad_par);
    int t;
    t = int'(b[7:6]);
    if (bad_par) m_par++;
    else if (bad_stop) m_quadro++;
    else if (t == 0) begin
      part_q.delete();
      part_q.push_back(b);
    end else if (part_q.size() != 0 && t == part_q.size()) begin
      part_q.push_back(b);
      if (part_q.size() == 4) begin
        for (int k = 0; k < 4; k++) m_out[k] = part_q[k];
        m_snap = {m_out[0], m_out[1], m_out[2], m_out[3]};
        m_pronto++;
        part_q.delete();
      end
    end else begin
      m_seq++;
      part_q.delete();
    end
  endtask

  task automatic model_reset();
    part_q.delete();
    for (int k = 0; k < 4; k++) m_out[k] = 8'h00;
  endtask

  // Drive one character on the line, then leave it idle
  task automatic send_byte(input logic [7:0] b, input bit bad_stop, input bit bad_par);
    @(negedge clock);
    entrada_serial = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      entrada_serial = b[i];
      repeat (CPB) @(negedge clock);
    end
`ifdef BITBAKERY_RX_PARITY_EN
    entrada_serial = (^b) ^ bad_par;
    repeat (CPB) @(negedge clock);
`endif
    entrada_serial = ~bad_stop;
    repeat (CPB) @(negedge clock);
    if (bad_stop && !bad_par) begin
      repeat (CPB) @(negedge clock);
      check_eq("hold_espera", 32'(db_estado_rx), 32'(ST_ESPERA_OCIOSO));
    end
    entrada_serial = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    model_byte(b, bad_stop, bad_par);
    $display("byte %02h stop_err=%0d par_err=%0d -> D=%02h %02h %02h %02h pronto_cnt=%0d",
             b, bad_stop, bad_par, D0, D1, D2, D3, n_pronto);
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".pronto_cnt"}, 32'(n_pronto), 32'(m_pronto));
    check_eq({tag, ".seq_cnt"},    32'(n_seq),    32'(m_seq));
    check_eq({tag, ".quadro_cnt"}, 32'(n_quadro), 32'(m_quadro));
    check_eq({tag, ".par_cnt"},    32'(n_par),    32'(m_par));
    check_eq({tag, ".D"}, {D0, D1, D2, D3}, {m_out[0], m_out[1], m_out[2], m_out[3]});
    check_eq({tag, ".fields"}, 32'({minigame, estado, jogada, dificuldade}),
             32'({m_out[0][5:4], m_out[0][3:0], m_out[2][5], m_out[1][5:0], m_out[2][4]}));
    check_eq({tag, ".db_idle"}, 32'(db_estado_rx), 32'(ST_OCIOSO));
    if (m_pronto > 0) check_eq({tag, ".frame_at_pronto"}, snap, m_snap);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".D"}, {D0, D1, D2, D3}, 32'h0);
    check_eq({tag, ".fields"}, 32'({minigame, estado, jogada, dificuldade}), 32'h0);
    check_eq({tag, ".pulses"}, 32'({pronto, erro_quadro, erro_paridade, erro_sequencia}), 32'h0);
    check_eq({tag, ".db"}, 32'(db_estado_rx), 32'(ST_OCIOSO));
  endtask

  initial begin
    logic [7:0] b;
    int         r;
    model_reset();

    // Power-on reset
    repeat (5) @(negedge clock);
    check_reset_outputs("por");
    reset = 1'b1;
    repeat (4) @(negedge clock);

    // Reference frame from the test plan
    send_byte(8'h27, 0, 0);
    send_byte(8'h55, 0, 0);
    send_byte(8'hB0, 0, 0);
    send_byte(8'hC0, 0, 0);
    check_all("frame1");
    check_eq("frame1.minigame", 32'(minigame), 32'd2);
    check_eq("frame1.estado", 32'(estado), 32'd7);
    check_eq("frame1.jogada", 32'(jogada), 32'b1010101);
    check_eq("frame1.dificuldade", 32'(dificuldade), 32'd1);

    // Missing tag 10
    send_byte(8'h27, 0, 0);
    send_byte(8'h55, 0, 0);
    send_byte(8'hC0, 0, 0);
    check_all("seq_err");

    // Stop-bit error then a full resend
    send_byte(8'h27, 0, 0);
    send_byte(8'h55, 1, 0);
    check_all("stop_err");
    send_byte(8'h1A, 0, 0);
    send_byte(8'h6B, 0, 0);
    send_byte(8'h8F, 0, 0);
    send_byte(8'hE3, 0, 0);
    check_all("resend");

    // Four-cycle glitch on an idle line
    @(negedge clock);
    entrada_serial = 1'b0;
    repeat (4) @(negedge clock);
    entrada_serial = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    $display("glitch 4 cycles");
    check_all("glitch");

    // Reset after the second byte of a frame
    send_byte(8'h27, 0, 0);
    send_byte(8'h55, 0, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("midframe_rst");
    reset = 1'b1;
    model_reset();
    repeat (4) @(negedge clock);
    $display("reset mid-frame released");
    send_byte(8'h43, 0, 0);
    send_byte(8'h99, 0, 0);
    check_all("after_rst_partial");
    send_byte(8'h03, 0, 0);
    send_byte(8'h7F, 0, 0);
    send_byte(8'hA5, 0, 0);
    send_byte(8'hFF, 0, 0);
    check_all("after_rst_frame");

`ifdef BITBAKERY_RX_PARITY_EN
    // Bad parity on 0x55 is discarded, a good one completes the frame
    send_byte(8'h27, 0, 0);
    send_byte(8'h55, 0, 1);
    check_all("par_err");
    send_byte(8'h55, 0, 0);
    send_byte(8'hB0, 0, 0);
    send_byte(8'hC0, 0, 0);
    check_all("par_ok");
`endif

    // Randomized tagged bytes, mostly in order
    for (int n = 0; n < 48; n++) begin
      r = int'($urandom_range(0, 9));
      b = 8'($urandom);
      if (r < 7)       b[7:6] = 2'(part_q.size());
      else if (r == 7) b[7:6] = 2'b00;
      send_byte(b, ($urandom_range(0, 11) == 0), 0);
      check_all($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
